four_bit_adder: RTL and testbench



---
 rtl/four_bit_adder_pkg.sv | 6 +
 rtl/four_bit_adder_full_adder_cell.sv | 16 +
 rtl/four_bit_adder.sv | 41 ++++
 tb/tb_four_bit_adder.sv | 124 ++++++++++++
 4 files changed

// File: rtl/four_bit_adder_pkg.sv
// Shared constants for the registered ripple-carry adder slice.
package four_bit_adder_pkg;

  localparam int unsigned ADDER_WIDTH = 4;

endpackage : four_bit_adder_pkg

// File: rtl/four_bit_adder_full_adder_cell.sv
// One-bit full adder used as the ripple-chain element of four_bit_adder.
module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  logic p;

  assign p  = a ^ b;
  assign s  = p ^ ci;
  assign co = (a & b) | (ci & p);

endmodule : full_adder_cell

// File: rtl/four_bit_adder.sv
// Registered WIDTH-bit ripple-carry adder: {cout, sum} <= a + b + cin, one-cycle latency.
module four_bit_adder
  import four_bit_adder_pkg::*;
#(
  parameter int unsigned WIDTH = ADDER_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum_next;

  assign carry[0] = cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    full_adder_cell u_cell (
      .a  (a[i]),
      .b  (b[i]),
      .ci (carry[i]),
      .s  (sum_next[i]),
      .co (carry[i+1])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sum  <= '0;
      cout <= 1'b0;
    end else begin
      sum  <= sum_next;
      cout <= carry[WIDTH];
    end
  end

endmodule : four_bit_adder

// File: tb/tb_four_bit_adder.sv
// Scoreboard bench for four_bit_adder: directed cases, exhaustive sweep, random stream with resets.
module tb_four_bit_adder;

  localparam int unsigned W = 4;

  typedef struct {
    logic [W-1:0] exp_sum;
    logic         exp_cout;
    string        name;
  } item_t;

  logic         clk;
  logic         rst;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic [W-1:0] sum;
  logic         cout;

  item_t q[$];
  int tests;
  int fails;
  bit done;

  four_bit_adder #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst  (rst),
    .a    (a),
    .b    (b),
    .cin  (cin),
    .sum  (sum),
    .cout (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain integer addition; reset forces a zero result.
  task automatic apply(input bit r, input int av, input int bv, input int cv, input string nm);
    item_t it;
    int total;
    rst = r;
    a   = av[W-1:0];
    b   = bv[W-1:0];
    cin = cv[0];
    total = r ? 0 : (av + bv + cv);
    it.exp_sum  = W'(total % (1 << W));
    it.exp_cout = (total >= (1 << W));
    it.name     = nm;
    q.push_back(it);
    @(posedge clk);
    #1;
  endtask

  // Monitor: each rising edge consumes the operand set issued before it.
  initial begin
    item_t it;
    forever begin
      @(posedge clk);
      if (q.size() > 0) begin
        it = q.pop_front();
        @(negedge clk);
        tests++;
        if (sum !== it.exp_sum || cout !== it.exp_cout) begin
          fails++;
          $display("FAIL %s: got cout=%b sum=%b, expected cout=%b sum=%b",
                   it.name, cout, sum, it.exp_cout, it.exp_sum);
        end
      end
    end
  end

  initial begin
    tests = 0;
    fails = 0;
    done  = 1'b0;

    apply(1, 15, 15, 1, "reset_0");
    apply(1, 15, 15, 1, "reset_1");

    apply(0, 3, 3, 0, "3+3+0");
    apply(0, 11, 8, 1, "11+8+1");
    apply(0, 15, 12, 1, "15+12+1");
    apply(0, 15, 0, 1, "15+0+1");
    apply(0, 15, 15, 1, "15+15+1");
    apply(0, 0, 0, 0, "0+0+0");

    for (int i = 0; i < 512; i++)
      apply(0, (i >> 5) & 15, (i >> 1) & 15, i & 1, "sweep");

    // Random stream with occasional mid-stream reset.
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(15) == 0)
        apply(1, $urandom_range(15), $urandom_range(15), $urandom_range(1), "rand_reset");
      else
        apply(0, $urandom_range(15), $urandom_range(15), $urandom_range(1), "rand");
    end

    apply(1, 15, 15, 1, "reset_midstream");
    apply(0, 9, 6, 1, "after_reset");
    rst = 1'b0;

    for (int t = 0; t < 10 && q.size() > 0; t++) @(posedge clk);
    @(negedge clk);
    @(negedge clk);
    if (q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain: got %0d pending results, expected 0", q.size());
    end
    done = 1'b1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    if (!done) begin
      $display("FAIL timeout: got no completion, expected finish before 200000");
      $fatal(1, "timeout");
    end
  end

endmodule : tb_four_bit_adder
